// File: rtl/mem_access.sv
// mem_access: memory stage responder between exe_mem and the data bus.
// Runs one req/gnt/rvalid transaction per load/store and stalls the pipe meanwhile.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        reg_we_i,
    input  logic [31:0] reg_wdata_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [3:0]  mem_op_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    output logic [4:0]  reg_waddr_o,
    output logic        reg_we_o,
    output logic [31:0] reg_wdata_o,
    output logic        mem_stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic [1:0]     off_q, off_d;
    logic [4:0]     rd_q, rd_d;
    logic           rwe_q, rwe_d;
    logic           we_q, we_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [29:0]    waddr_q, waddr_d;
    logic [31:0]    res_q, res_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           is_mem;
    logic           misal;
    logic [3:0]     be_in;
    logic [31:0]    wd_in;
    logic           timeout;

    function automatic logic [31:0] load_ext(logic [3:0] op, logic [1:0] off,
                                             logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (op)
            OP_LB:   load_ext = {{24{sh[7]}}, sh[7:0]};
            OP_LH:   load_ext = {{16{sh[15]}}, sh[15:0]};
            OP_LBU:  load_ext = {24'd0, sh[7:0]};
            OP_LHU:  load_ext = {16'd0, sh[15:0]};
            default: load_ext = sh;
        endcase
    endfunction

    // Request decode; unused op encodings above SW behave like NOP.
    always_comb begin
        is_mem = (mem_op_i != OP_NOP) && (mem_op_i <= OP_SW);
        misal  = 1'b0;
        be_in  = 4'hF;
        wd_in  = mem_data_i;
        case (mem_op_i)
            OP_LH, OP_LHU: misal = mem_addr_i[0];
            OP_LW:         misal = |mem_addr_i[1:0];
            OP_SB: begin
                be_in = 4'b0001 << mem_addr_i[1:0];
                wd_in = {4{mem_data_i[7:0]}};
            end
            OP_SH: begin
                misal = mem_addr_i[0];
                be_in = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                wd_in = {2{mem_data_i[15:0]}};
            end
            OP_SW:   misal = |mem_addr_i[1:0];
            default: misal = 1'b0;
        endcase
    end

    assign timeout = (cnt_q >= CNT_MAX);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        rd_d         = rd_q;
        rwe_d        = rwe_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        waddr_d      = waddr_q;
        res_d        = res_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = 32'd0;
        dbus_be_o    = 4'd0;
        dbus_wdata_o = 32'd0;
        reg_waddr_o  = 5'd0;
        reg_we_o     = 1'b0;
        reg_wdata_o  = 32'd0;
        mem_stall_o  = 1'b0;
        misalign_o   = 1'b0;
        bus_err_o    = 1'b0;
        case (state_q)
            IDLE: begin
                reg_waddr_o = reg_waddr_i;
                reg_wdata_o = reg_wdata_i;
                if (!is_mem) begin
                    reg_we_o = reg_we_i;
                end else if (misal) begin
                    misalign_o = 1'b1;
                end else begin
                    mem_stall_o = 1'b1;
                    op_d        = mem_op_i;
                    off_d       = mem_addr_i[1:0];
                    rd_d        = reg_waddr_i;
                    rwe_d       = reg_we_i;
                    we_d        = mem_we_i;
                    be_d        = be_in;
                    wdata_d     = wd_in;
                    waddr_d     = mem_addr_i[31:2];
                    res_d       = 32'd0;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                mem_stall_o  = 1'b1;
                dbus_req_o   = 1'b1;
                dbus_we_o    = we_q;
                dbus_addr_o  = {waddr_q, 2'b00};
                dbus_be_o    = be_q;
                dbus_wdata_o = wdata_q;
                cnt_d        = cnt_q + 1'b1;
                if (dbus_gnt_i) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else if (dbus_rvalid_i) begin
                        res_d   = load_ext(op_q, off_q, dbus_rdata_i);
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT: begin
                mem_stall_o = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                if (dbus_rvalid_i) begin
                    res_d   = load_ext(op_q, off_q, dbus_rdata_i);
                    state_d = DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                reg_waddr_o = rd_q;
                reg_we_o    = !we_q && rwe_q && !err_q;
                reg_wdata_o = res_q;
                bus_err_o   = err_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            off_q   <= 2'd0;
            rd_q    <= 5'd0;
            rwe_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            waddr_q <= 30'd0;
            res_q   <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            rwe_q   <= rwe_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized load/store transactions
// against an arithmetic reference model of the memory stage.
module tb_mem_access;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [3:0]  mem_op_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        mem_stall_o;
    logic        misalign_o;
    logic        bus_err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i),
        .reg_wdata_i(reg_wdata_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_op_i(mem_op_i), .dbus_req_o(dbus_req_o),
        .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
        .dbus_rdata_i(dbus_rdata_i), .reg_waddr_o(reg_waddr_o),
        .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
        .mem_stall_o(mem_stall_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o)
    );

    function automatic bit is_load(int op);
        return op >= 1 && op <= 5;
    endfunction

    function automatic int op_size(int op);
        if (op == 1 || op == 4 || op == 6) return 1;
        if (op == 2 || op == 5 || op == 7) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(int op, int off);
        int mask;
        if (is_load(op)) return 4'hF;
        mask = ((1 << op_size(op)) - 1) << off;
        return 4'(mask);
    endfunction

    function automatic logic [31:0] m_wd(int op, logic [31:0] d);
        if (op == 6) return (d & 32'hFF) * 32'h01010101;
        if (op == 7) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(int op, int off, logic [31:0] w);
        longint v;
        v = longint'(w >> (8 * off));
        case (op)
            1: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            2: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            4: v = v % 256;
            5: v = v % 65536;
            default: v = longint'(w);
        endcase
        return 32'(v);
    endfunction

    task automatic idle_inputs();
        mem_op_i      = 4'd0;
        mem_we_i      = 1'b0;
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
    endtask

    task automatic run_access(
        input int op, input logic [31:0] addr, input logic [31:0] data,
        input logic [4:0] rd, input logic rwe, input int gd, input int rdl,
        input logic [31:0] rword,
        output int stalls, output int reqs, output logic [31:0] a,
        output logic [3:0] be, output logic [31:0] wd, output logic we,
        output logic stable, output logic done, output logic o_we,
        output logic [31:0] o_wd, output logic [4:0] o_wa, output logic err);
        bit ld;
        ld = is_load(op);
        stalls = 0; reqs = 0; stable = 1'b1; done = 1'b0;
        a = 0; be = 0; wd = 0; we = 0; o_we = 0; o_wd = 0; o_wa = 0; err = 0;
        @(negedge clk_i);
        mem_op_i    = 4'(op);
        mem_we_i    = !ld;
        mem_addr_i  = addr;
        mem_data_i  = data;
        reg_waddr_i = rd;
        reg_we_i    = rwe;
        reg_wdata_i = $urandom();
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk_i);
            dbus_gnt_i    = (c == 1 + gd) || (c > 1 + gd && $urandom_range(0, 1) == 1);
            dbus_rvalid_i = (ld && c == 1 + gd + rdl) || (c == 0 && $urandom_range(0, 1) == 1);
            dbus_rdata_i  = (ld && c == 1 + gd + rdl) ? rword : $urandom();
            #1;
            if (mem_stall_o) stalls++;
            if (dbus_req_o) begin
                if (reqs > 0 && (a !== dbus_addr_o || be !== dbus_be_o ||
                                 wd !== dbus_wdata_o || we !== dbus_we_o))
                    stable = 1'b0;
                a = dbus_addr_o; be = dbus_be_o; wd = dbus_wdata_o; we = dbus_we_o;
                reqs++;
            end
            if (c > 0 && !mem_stall_o) begin
                done = 1'b1;
                o_we = reg_we_o; o_wd = reg_wdata_o; o_wa = reg_waddr_o;
                err  = bus_err_o;
            end
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

    int st, rq;
    logic [31:0] ra, rw, owd;
    logic [3:0] rb;
    logic rwe_o, stb, dn, owe, er;
    logic [4:0] owa;

    task automatic test_reset();
        rst_i = 1'b1;
        idle_inputs();
        reg_waddr_i = 0; reg_we_i = 0; reg_wdata_i = 0;
        mem_addr_i = 0; mem_data_i = 0; dbus_rdata_i = 0;
        #2;
        total++;
        if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o} !== '0) begin
            bad++; $display("FAIL reset_bus: req=%b addr=%h be=%h required 0", dbus_req_o, dbus_addr_o, dbus_be_o);
        end
        total++;
        if ({reg_we_o, reg_wdata_o, reg_waddr_o, mem_stall_o, misalign_o, bus_err_o} !== '0) begin
            bad++; $display("FAIL reset_out: we=%b stall=%b mis=%b err=%b required 0", reg_we_o, mem_stall_o, misalign_o, bus_err_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_store();
        run_access(8, 32'h100, 32'h11223344, 5'd3, 1'b1, 0, 0, 0,
                   st, rq, ra, rb, rw, rwe_o, stb, dn, owe, owd, owa, er);
        total++;
        if (st !== 2 || rq !== 1 || !dn) begin
            bad++; $display("FAIL sw_latency: stalls=%0d reqs=%0d done=%b required 2 1 1", st, rq, dn);
        end
        total++;
        if (ra !== 32'h100 || rb !== 4'hF || rwe_o !== 1'b1 || rw !== 32'h11223344) begin
            bad++; $display("FAIL sw_bus: addr=%h be=%h we=%b wd=%h required 100 f 1 11223344", ra, rb, rwe_o, rw);
        end
        total++;
        if (owe !== 1'b0) begin
            bad++; $display("FAIL sw_regwe: got %b required 0", owe);
        end
        run_access(6, 32'h103, 32'h000000AB, 5'd3, 1'b1, 0, 0, 0,
                   st, rq, ra, rb, rw, rwe_o, stb, dn, owe, owd, owa, er);
        total++;
        if (rb !== 4'b1000 || rw !== 32'hABABABAB || ra !== 32'h100) begin
            bad++; $display("FAIL sb_bus: be=%b wd=%h addr=%h required 1000 abababab 100", rb, rw, ra);
        end
        run_access(7, 32'h102, 32'h00001234, 5'd3, 1'b1, 0, 0, 0,
                   st, rq, ra, rb, rw, rwe_o, stb, dn, owe, owd, owa, er);
        total++;
        if (rb !== 4'b1100 || rw !== 32'h12341234) begin
            bad++; $display("FAIL sh_bus: be=%b wd=%h required 1100 12341234", rb, rw);
        end
    endtask

    task automatic test_load_ext();
        run_access(1, 32'h101, 0, 5'd7, 1'b1, 0, 1, 32'h00008000,
                   st, rq, ra, rb, rw, rwe_o, stb, dn, owe, owd, owa, er);
        total++;
        if (owd !== 32'hFFFFFF80 || owe !== 1'b1 || owa !== 5'd7) begin
            bad++; $display("FAIL lb: data=%h we=%b rd=%0d required ffffff80 1 7", owd, owe, owa);
        end
        run_access(4, 32'h101, 0, 5'd7, 1'b1, 0, 0, 32'h00008000,
                   st, rq, ra, rb, rw, rwe_o, stb, dn, owe, owd, owa, er);
        total++;
        if (owd !== 32'h00000080) begin
            bad++; $display("FAIL lbu: data=%h required 00000080", owd);
        end
        run_access(2, 32'h102, 0, 5'd9, 1'b1, 0, 0, 32'h80010000,
                   st, rq, ra, rb, rw, rwe_o, stb, dn, owe, owd, owa, er);
        total++;
        if (owd !== 32'hFFFF8001 || rb !== 4'hF || rwe_o !== 1'b0) begin
            bad++; $display("FAIL lh: data=%h be=%h we=%b required ffff8001 f 0", owd, rb, rwe_o);
        end
    endtask

    task automatic test_latency();
        run_access(3, 32'h300, 0, 5'd4, 1'b1, 3, 2, 32'hCAFEF00D,
                   st, rq, ra, rb, rw, rwe_o, stb, dn, owe, owd, owa, er);
        total++;
        if (st !== 7 || rq !== 4 || !stb) begin
            bad++; $display("FAIL lw_slow: stalls=%0d reqs=%0d stable=%b required 7 4 1", st, rq, stb);
        end
        total++;
        if (owd !== 32'hCAFEF00D || owe !== 1'b1 || er !== 1'b0) begin
            bad++; $display("FAIL lw_slow_data: data=%h we=%b err=%b required cafef00d 1 0", owd, owe, er);
        end
        run_access(3, 32'h304, 0, 5'd4, 1'b1, 0, 0, 32'h01020304,
                   st, rq, ra, rb, rw, rwe_o, stb, dn, owe, owd, owa, er);
        total++;
        if (st !== 2 || owd !== 32'h01020304) begin
            bad++; $display("FAIL lw_fast: stalls=%0d data=%h required 2 01020304", st, owd);
        end
    endtask

    task automatic test_misalign_nop();
        @(negedge clk_i);
        mem_op_i = 4'd3; mem_we_i = 1'b0; mem_addr_i = 32'h102; reg_we_i = 1'b1;
        #1;
        total++;
        if (misalign_o !== 1'b1 || mem_stall_o !== 1'b0 || dbus_req_o !== 1'b0 || reg_we_o !== 1'b0) begin
            bad++; $display("FAIL misalign: mis=%b stall=%b req=%b we=%b required 1 0 0 0", misalign_o, mem_stall_o, dbus_req_o, reg_we_o);
        end
        @(negedge clk_i);
        idle_inputs();
        reg_wdata_i = $urandom(); reg_waddr_i = 5'd17; reg_we_i = 1'b1;
        #1;
        total++;
        if (misalign_o !== 1'b0 || reg_wdata_o !== reg_wdata_i || reg_we_o !== 1'b1 || reg_waddr_o !== 5'd17) begin
            bad++; $display("FAIL nop_pass: mis=%b data=%h we=%b rd=%0d required 0 %h 1 17", misalign_o, reg_wdata_o, reg_we_o, reg_waddr_o, reg_wdata_i);
        end
    endtask

    task automatic test_timeout();
        run_access(3, 32'h400, 0, 5'd5, 1'b1, 100, 0, 0,
                   st, rq, ra, rb, rw, rwe_o, stb, dn, owe, owd, owa, er);
        total++;
        if (rq !== TO || st !== TO + 1 || !dn) begin
            bad++; $display("FAIL timeout_len: reqs=%0d stalls=%0d done=%b required %0d %0d 1", rq, st, dn, TO, TO + 1);
        end
        total++;
        if (er !== 1'b1 || owe !== 1'b0) begin
            bad++; $display("FAIL timeout_err: err=%b we=%b required 1 0", er, owe);
        end
        #1;
        total++;
        if (bus_err_o !== 1'b0) begin
            bad++; $display("FAIL timeout_pulse: err=%b required 0", bus_err_o);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        mem_op_i = 4'd3; mem_we_i = 1'b0; mem_addr_i = 32'h500; reg_we_i = 1'b1;
        reg_waddr_i = 5'd2;
        @(negedge clk_i);
        dbus_gnt_i = 1'b1;
        @(negedge clk_i);
        dbus_gnt_i = 1'b0;
        #1;
        total++;
        if (mem_stall_o !== 1'b1 || dbus_req_o !== 1'b0) begin
            bad++; $display("FAIL wait_state: stall=%b req=%b required 1 0", mem_stall_o, dbus_req_o);
        end
        #1;
        mem_op_i = 4'd0; reg_wdata_i = 32'h5A5A0001;
        rst_i = 1'b1;
        #1;
        total++;
        if (dbus_req_o !== 1'b0 || mem_stall_o !== 1'b0 || reg_we_o !== 1'b1 || reg_wdata_o !== 32'h5A5A0001) begin
            bad++; $display("FAIL reset_mid: req=%b stall=%b we=%b data=%h required 0 0 1 5a5a0001", dbus_req_o, mem_stall_o, reg_we_o, reg_wdata_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        dbus_rvalid_i = 1'b1;
        #1;
        total++;
        if (mem_stall_o !== 1'b0 || reg_wdata_o !== 32'h5A5A0001) begin
            bad++; $display("FAIL reset_idle: stall=%b data=%h required 0 5a5a0001", mem_stall_o, reg_wdata_o);
        end
        dbus_rvalid_i = 1'b0;
    endtask

    task automatic test_random();
        int op, sz, off, gd, rdl;
        logic [31:0] addr, data, word, ea;
        logic [4:0] rd;
        logic rwe;
        for (int i = 0; i < 30; i++) begin
            op   = $urandom_range(1, 8);
            sz   = op_size(op);
            off  = ($urandom_range(0, 3) / sz) * sz;
            addr = ($urandom() & 32'hFFFFFFFC) | off;
            data = $urandom();
            word = $urandom();
            rd   = 5'($urandom_range(1, 31));
            rwe  = 1'($urandom_range(0, 1));
            gd   = $urandom_range(0, 3);
            rdl  = $urandom_range(0, 3);
            ea   = addr & 32'hFFFFFFFC;
            run_access(op, addr, data, rd, rwe, gd, rdl, word,
                       st, rq, ra, rb, rw, rwe_o, stb, dn, owe, owd, owa, er);
            total++;
            if (!dn || st !== 2 + gd + (is_load(op) ? rdl : 0) || rq !== gd + 1 || !stb) begin
                bad++; $display("FAIL rnd_timing[%0d]: op=%0d done=%b stalls=%0d reqs=%0d stable=%b gd=%0d rd=%0d", i, op, dn, st, rq, stb, gd, rdl);
            end
            total++;
            if (ra !== ea || rb !== m_be(op, off) || rwe_o !== !is_load(op) ||
                (!is_load(op) && rw !== m_wd(op, data))) begin
                bad++; $display("FAIL rnd_bus[%0d]: op=%0d addr=%h be=%b wd=%h we=%b required %h %b %h %b", i, op, ra, rb, rw, rwe_o, ea, m_be(op, off), m_wd(op, data), !is_load(op));
            end
            total++;
            if (er !== 1'b0 || owe !== (is_load(op) && rwe) ||
                (is_load(op) && (owd !== m_load(op, off, word) || owa !== rd))) begin
                bad++; $display("FAIL rnd_result[%0d]: op=%0d we=%b data=%h rd=%0d err=%b required %b %h %0d 0", i, op, owe, owd, owa, er, is_load(op) && rwe, m_load(op, off, word), rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_ext();
        test_latency();
        test_misalign_nop();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
